slot_fee_meter: RTL and testbench

- Downstream consumer of the parking FSM's accepted entry/exit events.
- Keeps a per-slot dwell-time counter advanced by the 1 Hz tick from the frequency divider.
- On a valid exit, captures that slot's dwell time and computes a per-started-minute fee sequentially.
- Presents the fee as two BCD digits with a valid/ready handshake to the multiplexed display.

---
 rtl/slot_fee_meter.sv | 177 +++++++++++++++++
 tb/tb_slot_fee_meter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/slot_fee_meter.sv
// Per-slot dwell timer and started-minute fee calculator with a BCD valid/ready output.
// Optional macro FEE_GRACE_EN: dwell below one minute is charged 00.
module slot_fee_meter #(
   parameter int NUM_SLOTS = 4,
   parameter int SEC_W     = 12,
   parameter int RATE      = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tick_1hz,
   input  logic                 park_pulse,
   input  logic [1:0]           park_slot,
   input  logic                 leave_pulse,
   input  logic [1:0]           leave_slot,
   input  logic                 fee_ready,
   output logic                 fee_valid,
   output logic [3:0]           fee_tens,
   output logic [3:0]           fee_ones,
   output logic                 busy,
   output logic                 drop_err,
   output logic [NUM_SLOTS-1:0] occupied,
   output logic [NUM_SLOTS-1:0] sat_flag
);

   localparam int MAX_MIN  = ((2**SEC_W - 1) + 59) / 60;
   localparam int MIN_W    = $clog2(MAX_MIN + 1);
   localparam int PROD_RAW = MIN_W + $clog2(RATE + 1);
   localparam int PROD_W   = (PROD_RAW < 8) ? 8 : PROD_RAW;

   localparam logic [SEC_W-1:0]  SEC_MAX = '1;
   localparam logic [SEC_W-1:0]  SEC_ONE = SEC_W'(1);
   localparam logic [SEC_W-1:0]  SIXTY   = SEC_W'(60);
   localparam logic [MIN_W-1:0]  MIN_ONE = MIN_W'(1);
   localparam logic [PROD_W-1:0] FEE_CAP = PROD_W'(99);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DIV,
      S_BCD,
      S_VALID
   } state_t;

   state_t               r_state;
   logic [SEC_W-1:0]     r_cnt [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] r_occ;
   logic [NUM_SLOTS-1:0] r_sat;
   logic [SEC_W-1:0]     r_rem;
   logic [MIN_W-1:0]     r_min;
   logic [6:0]           r_fee;
   logic [3:0]           r_tens;
   logic [3:0]           r_ones;
   logic                 r_valid;
   logic                 r_busy;
   logic                 r_drop;

   logic                 w_leaveHit;
   logic                 w_accept;
   logic                 w_drop;
   logic [MIN_W-1:0]     w_minUp;
   logic [PROD_W-1:0]    w_prod;
   logic [6:0]           w_feeSat;
   logic [6:0]           w_fee;

   // Leave is judged against occupancy before this cycle's park/leave updates.
   assign w_leaveHit = leave_pulse && r_occ[leave_slot];
   assign w_accept   = w_leaveHit && (r_state == S_IDLE);
   assign w_drop     = w_leaveHit && (r_state != S_IDLE);

   assign w_minUp  = (r_rem != '0) ? (r_min + MIN_ONE) : r_min;
   assign w_prod   = PROD_W'(w_minUp) * PROD_W'(RATE);
   assign w_feeSat = (w_prod > FEE_CAP) ? 7'd99 : w_prod[6:0];

`ifdef FEE_GRACE_EN
   // No whole minute was subtracted, so the dwell was under 60 s.
   assign w_fee = (r_min == '0) ? 7'd0 : w_feeSat;
`else
   assign w_fee = w_feeSat;
`endif

   // Dwell counters: tick, then leave, then park, so a same-cycle park reopens the slot.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_occ <= '0;
         r_sat <= '0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            if (tick_1hz && r_occ[i]) begin
               if (r_cnt[i] != SEC_MAX) begin
                  r_cnt[i] <= r_cnt[i] + SEC_ONE;
               end
               if (r_cnt[i] >= (SEC_MAX - SEC_ONE)) begin
                  r_sat[i] <= 1'b1;
               end
            end
            if (w_leaveHit && (leave_slot == 2'(i))) begin
               r_occ[i] <= 1'b0;
               r_cnt[i] <= '0;
            end
            if (park_pulse && (park_slot == 2'(i))) begin
               r_occ[i] <= 1'b1;
               r_cnt[i] <= '0;
               r_sat[i] <= 1'b0;
            end
         end
      end
   end

   // Fee engine: repeated subtraction for minutes, then for BCD tens.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_rem   <= '0;
         r_min   <= '0;
         r_fee   <= '0;
         r_tens  <= '0;
         r_ones  <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_drop  <= 1'b0;
      end else begin
         r_drop <= w_drop;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_rem   <= r_cnt[leave_slot];
                  r_min   <= '0;
                  r_tens  <= '0;
                  r_ones  <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_DIV;
               end
            end
            S_DIV: begin
               if (r_rem >= SIXTY) begin
                  r_rem <= r_rem - SIXTY;
                  r_min <= r_min + MIN_ONE;
               end else begin
                  r_fee   <= w_fee;
                  r_state <= S_BCD;
               end
            end
            S_BCD: begin
               if (r_fee >= 7'd10) begin
                  r_fee  <= r_fee - 7'd10;
                  r_tens <= r_tens + 4'd1;
               end else begin
                  r_ones  <= r_fee[3:0];
                  r_valid <= 1'b1;
                  r_state <= S_VALID;
               end
            end
            S_VALID: begin
               if (fee_ready) begin
                  r_valid <= 1'b0;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign fee_valid = r_valid;
   assign fee_tens  = r_tens;
   assign fee_ones  = r_ones;
   assign busy      = r_busy;
   assign drop_err  = r_drop;
   assign occupied  = r_occ;
   assign sat_flag  = r_sat;

endmodule

// File: tb/tb_slot_fee_meter.sv
// Scoreboard bench for slot_fee_meter with RATE=2 so the 99 fee cap is reachable.
module tb_slot_fee_meter;

   localparam int RATE = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic       tick_1hz;
   logic       park_pulse;
   logic [1:0] park_slot;
   logic       leave_pulse;
   logic [1:0] leave_slot;
   logic       fee_ready;
   logic       fee_valid;
   logic [3:0] fee_tens;
   logic [3:0] fee_ones;
   logic       busy;
   logic       drop_err;
   logic [3:0] occupied;
   logic [3:0] sat_flag;

   int         testsRun = 0;
   int         testsFailed = 0;
   logic [7:0] expQ [$];
   logic [7:0] monExp;

   always #5 clk = ~clk;

   slot_fee_meter #(
      .NUM_SLOTS(4),
      .SEC_W    (12),
      .RATE     (RATE)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .tick_1hz   (tick_1hz),
      .park_pulse (park_pulse),
      .park_slot  (park_slot),
      .leave_pulse(leave_pulse),
      .leave_slot (leave_slot),
      .fee_ready  (fee_ready),
      .fee_valid  (fee_valid),
      .fee_tens   (fee_tens),
      .fee_ones   (fee_ones),
      .busy       (busy),
      .drop_err   (drop_err),
      .occupied   (occupied),
      .sat_flag   (sat_flag)
   );

   // Compare one named value and count the result.
   task automatic checkOutput(input string name, input int actual, input int expected);
      testsRun++;
      if (actual != expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, actual, expected);
      end
   endtask

   // Monitor: every accepted transfer pops the oldest expected BCD fee.
   always @(negedge clk) begin
      if (reset && fee_valid && fee_ready) begin
         if (expQ.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL unexpected_fee: got 'h%0h, expected no transfer", {fee_tens, fee_ones});
         end else begin
            monExp = expQ.pop_front();
            checkOutput("fee_digits", int'({fee_tens, fee_ones}), int'(monExp));
         end
      end
   end

   // Drive one cycle of park/leave pulses; returns just after the capturing edge.
   task automatic applyStimulus(input bit park, input logic [1:0] pSlot,
                                input bit leave, input logic [1:0] lSlot);
      park_pulse  = park;
      park_slot   = pSlot;
      leave_pulse = leave;
      leave_slot  = lSlot;
      @(posedge clk);
      #1;
      park_pulse  = 1'b0;
      leave_pulse = 1'b0;
   endtask

   task automatic applyTicks(input int n);
      tick_1hz = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      tick_1hz = 1'b0;
   endtask

   // Count busy cycles before fee_valid rises, bounded so a stuck DUT still ends the run.
   task automatic waitFee(input string name, input int expCycles);
      int cyc;
      bit seen;
      cyc  = 0;
      seen = 1'b0;
      for (int g = 0; g < 500 && !seen; g++) begin
         @(negedge clk);
         if (fee_valid) seen = 1'b1;
         else if (busy) cyc++;
      end
      checkOutput({name, "_seen"}, int'(seen), 1);
      if (seen) checkOutput({name, "_cycles"}, cyc, expCycles);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset       = 1'b0;
      tick_1hz    = 1'b1;
      park_pulse  = 1'b1;
      park_slot   = 2'd2;
      leave_pulse = 1'b1;
      leave_slot  = 2'd2;
      fee_ready   = 1'b1;

      // Reset held while every input toggles.
      repeat (3) @(negedge clk);
      checkOutput("rst_fee_valid", int'(fee_valid), 0);
      checkOutput("rst_digits", int'({fee_tens, fee_ones}), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_drop_err", int'(drop_err), 0);
      checkOutput("rst_occupied", int'(occupied), 0);
      checkOutput("rst_sat_flag", int'(sat_flag), 0);
      tick_1hz    = 1'b0;
      park_pulse  = 1'b0;
      leave_pulse = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;

      // 125 s -> 3 minutes -> 6; DIV 3 + BCD 1.
      applyStimulus(1'b1, 2'd2, 1'b0, 2'd0);
      checkOutput("park_occupied", int'(occupied), 'b0100);
      applyTicks(125);
      expQ.push_back(8'h06);
      applyStimulus(1'b0, 2'd0, 1'b1, 2'd2);
      waitFee("basic", 4);
      checkOutput("basic_occupied", int'(occupied[2]), 0);

      // Leave on an empty slot is silent.
      applyStimulus(1'b0, 2'd0, 1'b1, 2'd2);
      @(negedge clk);
      checkOutput("empty_leave_drop", int'(drop_err), 0);
      checkOutput("empty_leave_busy", int'(busy), 0);
      @(posedge clk);
      #1;

      // 600 s -> 10 minutes -> 20; DIV 11 + BCD 3.
      applyStimulus(1'b1, 2'd3, 1'b0, 2'd0);
      applyTicks(600);
      expQ.push_back(8'h20);
      applyStimulus(1'b0, 2'd0, 1'b1, 2'd3);
      waitFee("ten_min", 14);

      // Saturation: 4095 s -> 69 minutes -> 138 capped to 99; DIV 69 + BCD 10.
      applyStimulus(1'b1, 2'd0, 1'b0, 2'd0);
      applyTicks(5000);
      @(negedge clk);
      checkOutput("sat_flag", int'(sat_flag), 'b0001);
      @(posedge clk);
      #1;
      expQ.push_back(8'h99);
      applyStimulus(1'b0, 2'd0, 1'b1, 2'd0);
      waitFee("saturate", 79);

      // Drop while a result is pending.
      fee_ready = 1'b0;
      applyStimulus(1'b1, 2'd1, 1'b0, 2'd0);
      applyStimulus(1'b1, 2'd3, 1'b0, 2'd0);
      applyTicks(60);
      expQ.push_back(8'h02);
      applyStimulus(1'b0, 2'd0, 1'b1, 2'd1);
      waitFee("one_min", 3);
      applyStimulus(1'b0, 2'd0, 1'b1, 2'd3);
      @(negedge clk);
      checkOutput("drop_err_pulse", int'(drop_err), 1);
      checkOutput("drop_occupied3", int'(occupied[3]), 0);
      checkOutput("drop_pending_valid", int'(fee_valid), 1);
      checkOutput("drop_pending_digits", int'({fee_tens, fee_ones}), 'h02);
      @(negedge clk);
      checkOutput("drop_err_clear", int'(drop_err), 0);
      checkOutput("drop_still_valid", int'(fee_valid), 1);
      @(posedge clk);
      #1;
      fee_ready = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("handshake_valid_drop", int'(fee_valid), 0);
      checkOutput("handshake_busy_drop", int'(busy), 0);
      @(posedge clk);
      #1;

      // Same-cycle park and leave on slot 1 at 30 s.
      applyStimulus(1'b1, 2'd1, 1'b0, 2'd0);
      applyTicks(30);
`ifdef FEE_GRACE_EN
      expQ.push_back(8'h00);
`else
      expQ.push_back(8'h02);
`endif
      applyStimulus(1'b1, 2'd1, 1'b1, 2'd1);
      checkOutput("reopen_occupied1", int'(occupied[1]), 1);
      waitFee("same_cycle", 2);

      // Reopened counter is zero: immediate leave charges 00.
      expQ.push_back(8'h00);
      applyStimulus(1'b0, 2'd0, 1'b1, 2'd1);
      waitFee("zero_dwell", 2);
      checkOutput("zero_occupied1", int'(occupied[1]), 0);

      // Reset two cycles into DIV discards the calculation.
      applyStimulus(1'b1, 2'd2, 1'b0, 2'd0);
      applyTicks(300);
      applyStimulus(1'b0, 2'd0, 1'b1, 2'd2);
      @(negedge clk);
      @(negedge clk);
      #1;
      reset = 1'b0;
      #1;
      checkOutput("midrst_valid", int'(fee_valid), 0);
      checkOutput("midrst_busy", int'(busy), 0);
      checkOutput("midrst_occupied", int'(occupied), 0);
      checkOutput("midrst_sat", int'(sat_flag), 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (10) @(negedge clk);
      checkOutput("postrst_busy", int'(busy), 0);
      checkOutput("postrst_valid", int'(fee_valid), 0);
      @(posedge clk);
      #1;

      checkOutput("queue_empty", expQ.size(), 0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
